normalise_sum: RTL and testbench

//  Post-addition normaliser and IEEE-754 packer for the HCORDIC datapath; the return leg of the align stage.
//  - Align right-shifts the smaller operand. This block left- or right-shifts the 28-bit sum back to 1.xxx form.
//  - It then rounds to nearest-even and packs a 32-bit single-precision result.
//  - It is multi-cycle: at most SHIFT_STEP bit positions per cycle, under a valid/ready handshake on both sides.

---
 rtl/normalise_sum_if.sv | 27 ++
 rtl/normalise_sum.sv | 133 +++++++++++++
 tb/tb_normalise_sum.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/normalise_sum_if.sv
// Handshake bundle between the align stage, the normaliser and its consumer.
// The slave side is the normaliser; the master side drives operands and takes results.
interface normalise_sum_if;
    logic        valid_in;
    logic        ready_in;
    logic [1:0]  idle_in;
    logic [31:0] sout_in;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [27:0] sum_in;
    logic [7:0]  InsTag_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] sout_Normalise;
    logic [7:0]  InsTag_Normalise;
    logic [1:0]  idle_Normalise;

    modport slave (
        input  valid_in, idle_in, sout_in, sign_in, exp_in, sum_in, InsTag_in, ready_out,
        output ready_in, valid_out, sout_Normalise, InsTag_Normalise, idle_Normalise
    );

    modport master (
        output valid_in, idle_in, sout_in, sign_in, exp_in, sum_in, InsTag_in, ready_out,
        input  ready_in, valid_out, sout_Normalise, InsTag_Normalise, idle_Normalise
    );
endinterface

// File: rtl/normalise_sum.sv
// Post-addition normaliser: shifts the 28-bit sum back to 1.xxx form a few bits per cycle,
// rounds to nearest-even and packs an IEEE-754 single-precision word.
module normalise_sum #(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic           clock,
    input  logic           reset,
    normalise_sum_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_PACK,
        S_HOLD
    } state_t;

    localparam logic [1:0] PUT_IDLE = 2'b10;
    localparam logic [8:0] STEP     = 9'(SHIFT_STEP);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sign;
    logic [8:0]  r_exp;
    logic [27:0] r_sum;
    logic [7:0]  r_tag;
    logic [1:0]  r_idle;
    logic [31:0] r_sout;

    logic [4:0]  w_lz;
    logic [8:0]  w_k;
    logic        w_round_up;
    logic [24:0] w_mant;
    logic [8:0]  w_pack_exp;
    logic [23:0] w_pack_mant;
    logic [31:0] w_pack_word;

    // Leading zeros above the hidden bit; the highest set bit wins the loop.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i <= 26; i++) begin
            if (r_sum[i]) w_lz = 5'(26 - i);
        end
    end

    // Shift distance is capped so the exponent never drops below 1.
    always_comb begin
        w_k = {4'b0, w_lz};
        if (w_k > STEP) w_k = STEP;
        if (w_k > r_exp - 9'd1) w_k = r_exp - 9'd1;
    end

    always_comb begin
        w_round_up  = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
        w_mant      = {1'b0, r_sum[26:3]} + 25'(w_round_up);
        w_pack_exp  = r_exp + 9'(w_mant[24]);
        w_pack_mant = w_mant[24] ? 24'h800000 : w_mant[23:0];
        if (r_sum == '0)
            w_pack_word = {r_sign, 31'b0};
        else if (w_pack_exp >= 9'd255)
            w_pack_word = {r_sign, 8'hFF, 23'b0};
        else if (w_pack_exp == 9'd1 && !w_pack_mant[23])
            w_pack_word = {r_sign, 8'h00, w_pack_mant[22:0]};
        else
            w_pack_word = {r_sign, w_pack_exp[7:0], w_pack_mant[22:0]};
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.valid_in) w_state_next = (bus.idle_in == PUT_IDLE) ? S_HOLD : S_NORM;
            S_NORM: begin
                if (r_sum == '0 || r_sum[27] || r_sum[26] || r_exp <= 9'd1)
                    w_state_next = S_PACK;
            end
            S_PACK: w_state_next = S_HOLD;
            S_HOLD: if (bus.ready_out) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_sum  <= '0;
            r_tag  <= '0;
            r_idle <= '0;
            r_sout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        r_sign <= bus.sign_in;
                        r_exp  <= {1'b0, bus.exp_in};
                        r_sum  <= bus.sum_in;
                        r_tag  <= bus.InsTag_in;
                        r_idle <= bus.idle_in;
                        if (bus.idle_in == PUT_IDLE) r_sout <= bus.sout_in;
                    end
                end
                S_NORM: begin
                    if (r_sum != '0) begin
                        if (r_sum[27]) begin
                            // Carry: drop one bit, folding it into sticky.
                            r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
                            r_exp <= r_exp + 9'd1;
                        end else if (!r_sum[26] && r_exp > 9'd1) begin
                            r_sum <= r_sum << w_k;
                            r_exp <= r_exp - w_k;
                        end
                    end
                end
                S_PACK:  r_sout <= w_pack_word;
                default: ;
            endcase
        end
    end

    assign bus.ready_in         = (r_state == S_IDLE);
    assign bus.valid_out        = (r_state == S_HOLD);
    assign bus.sout_Normalise   = r_sout;
    assign bus.InsTag_Normalise = r_tag;
    assign bus.idle_Normalise   = r_idle;

endmodule

// File: tb/tb_normalise_sum.sv
// Bench for normalise_sum: directed corner cases plus random operands scored
// against an arithmetic model of normalisation, rounding and latency.
module tb_normalise_sum;

    localparam int STEP = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    normalise_sum_if bus();

    normalise_sum #(.SHIFT_STEP(STEP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: normalise with plain arithmetic, round with remainder tests.
    function automatic void model(input logic sgn, input logic [7:0] ex, input logic [27:0] sm,
                                  input logic [1:0] idl, input logic [31:0] so,
                                  output logic [31:0] word, output int lat);
        longint s;
        longint m;
        longint rem;
        int     e;
        int     lz;
        int     total;
        logic [8:0] e9;
        logic [23:0] m24;
        if (idl == 2'b10) begin
            word = so;
            lat  = 1;
            return;
        end
        s = longint'(sm);
        e = int'(ex);
        if (s == 0) begin
            word = {sgn, 31'b0};
            lat  = 3;
            return;
        end
        if (s >= (64'd1 << 27)) begin
            s = (s / 2) | (s % 2);
            e = e + 1;
            lat = 3;
        end else begin
            lz = 0;
            while ((s * (64'd1 << lz)) < (64'd1 << 26)) lz++;
            total = (e > 1) ? ((lz < e - 1) ? lz : e - 1) : 0;
            lat = 3 + (total + STEP - 1) / STEP;
            s = s * (64'd1 << total);
            e = e - total;
        end
        m   = s / 8;
        rem = s % 8;
        if (rem > 4 || (rem == 4 && (m % 2) == 1)) m = m + 1;
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        e9  = 9'(e);
        m24 = 24'(m);
        if (e >= 255)                        word = {sgn, 8'hFF, 23'b0};
        else if (e == 1 && m < (64'd1 << 23)) word = {sgn, 8'h00, m24[22:0]};
        else                                  word = {sgn, e9[7:0], m24[22:0]};
    endfunction

    task automatic send(input logic sgn, input logic [7:0] ex, input logic [27:0] sm,
                        input logic [1:0] idl, input logic [31:0] so, input logic [7:0] tg);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!bus.ready_in && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("ready_in_timeout", 64'(guard >= 200), 64'd0);
        bus.sign_in   = sgn;
        bus.exp_in    = ex;
        bus.sum_in    = sm;
        bus.idle_in   = idl;
        bus.sout_in   = so;
        bus.InsTag_in = tg;
        bus.valid_in  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.valid_in  = 1'b0;
    endtask

    // Called at the first negedge after the accept edge; returns cycles until valid_out.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.valid_out && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic op(input string name, input logic sgn, input logic [7:0] ex, input logic [27:0] sm,
                      input logic [1:0] idl, input logic [31:0] so, input logic [7:0] tg,
                      input logic [31:0] exp_word, input int exp_lat);
        int lat;
        send(sgn, ex, sm, idl, so, tg);
        wait_valid(lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " sout"}, 64'(bus.sout_Normalise), 64'(exp_word));
        check({name, " tag"}, 64'(bus.InsTag_Normalise), 64'(tg));
        check({name, " idle"}, 64'(bus.idle_Normalise), 64'(idl));
        @(negedge clock);
        check({name, " release"}, 64'({bus.valid_out, bus.ready_in}), 64'b01);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] held;
        int          lat;
        logic [27:0] sm;
        logic [7:0]  ex;
        logic [1:0]  idl;

        bus.valid_in  = 1'b0;
        bus.idle_in   = 2'b00;
        bus.sout_in   = '0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.sum_in    = '0;
        bus.InsTag_in = '0;
        bus.ready_out = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset ready_in", 64'(bus.ready_in), 64'd1);
        check("reset valid_out", 64'(bus.valid_out), 64'd0);
        check("reset outputs", {22'b0, bus.sout_Normalise, bus.InsTag_Normalise, bus.idle_Normalise}, 64'd0);
        reset = 1'b1;

        op("one",        1'b0, 8'd127, 28'h4000000, 2'b00, 32'h0,        8'h5A, 32'h3F800000, 3);
        op("carry",      1'b0, 8'd127, 28'h8000000, 2'b01, 32'h0,        8'h11, 32'h40000000, 3);
        op("carry_inf",  1'b0, 8'd254, 28'h8000000, 2'b00, 32'h0,        8'h12, 32'h7F800000, 3);
        op("deep",       1'b0, 8'd127, 28'h0000008, 2'b00, 32'h0,        8'h13, 32'h34000000, 9);
        op("denormal",   1'b0, 8'd3,   28'h0100000, 2'b00, 32'h0,        8'h14, 32'h00080000, 4);
        op("zero",       1'b1, 8'd90,  28'h0000000, 2'b00, 32'h0,        8'h15, 32'h80000000, 3);
        op("tie_ovf",    1'b0, 8'd127, 28'h7FFFFFC, 2'b00, 32'h0,        8'h16, 32'h40000000, 3);
        op("tie_even",   1'b0, 8'd127, 28'h4000004, 2'b00, 32'h0,        8'h17, 32'h3F800000, 3);
        op("put_idle",   1'b0, 8'd1,   28'h0000001, 2'b10, 32'hDEADBEEF, 8'h18, 32'hDEADBEEF, 1);

        // Downstream stall with a competing request that must be ignored.
        bus.ready_out = 1'b0;
        send(1'b1, 8'd130, 28'h2000000, 2'b00, 32'h0, 8'h77);
        wait_valid(lat);
        check("stall latency", 64'(lat), 64'd4);
        held = bus.sout_Normalise;
        check("stall sout", 64'(held), 64'hC0800000);
        bus.valid_in = 1'b1;
        bus.sum_in   = 28'h8000000;
        bus.idle_in  = 2'b10;
        bus.sout_in  = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall hold", {bus.valid_out, bus.ready_in, bus.InsTag_Normalise, bus.sout_Normalise},
                  {1'b1, 1'b0, 8'h77, held});
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        @(negedge clock);
        check("stall release", 64'({bus.valid_out, bus.ready_in}), 64'b01);

        // Reset while normalising discards the operation.
        send(1'b0, 8'd127, 28'h0000008, 2'b00, 32'h0, 8'h99);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset valid_out", 64'(bus.valid_out), 64'd0);
        check("midreset ready_in", 64'(bus.ready_in), 64'd1);
        check("midreset sout", 64'(bus.sout_Normalise), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("postreset idle", 64'({bus.valid_out, bus.ready_in}), 64'b01);

        for (int i = 0; i < 150; i++) begin
            sm = 28'($urandom()) >> $urandom_range(0, 28);
            ex = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ex = 8'($urandom_range(0, 4));
            idl = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            model(1'($urandom()), ex, sm, idl, 32'($urandom()), w, lat);
            begin
                logic        s_bit;
                logic [31:0] so;
                s_bit = 1'($urandom());
                so    = 32'($urandom());
                model(s_bit, ex, sm, idl, so, w, lat);
                op("random", s_bit, ex, sm, idl, so, 8'($urandom()), w, lat);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
